bin32_to_bcd8: RTL and testbench

BIN32_TO_BCD8 -- requirements
Module: bin32_to_bcd8

---
 rtl/bin32_to_bcd8_pkg.sv | 24 ++
 rtl/bin32_to_bcd8_digit_adj.sv | 11 +
 rtl/bin32_to_bcd8.sv | 101 ++++++++++
 tb/tb_bin32_to_bcd8.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bin32_to_bcd8_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin32_to_bcd8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int unsigned NUM_BITS_DEF   = 32;
  localparam int unsigned NUM_DIGITS_DEF = 8;

  // ceil(nbits*log10(2)) with log10(2) ~ 0.30103, widened so at least one
  // digit always sits above the presented digits for the overflow test.
  function automatic int unsigned scratch_digits(input int unsigned nbits,
                                                 input int unsigned ndig);
    int unsigned d;
    d = (nbits * 30103 + 99999) / 100000;
    return (d > ndig) ? d : ndig + 1;
  endfunction

  localparam int unsigned SCR_DIGITS_DEF = scratch_digits(NUM_BITS_DEF, NUM_DIGITS_DEF);

endpackage

// File: rtl/bin32_to_bcd8_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin32_to_bcd8.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// saturating to all nines with an overflow flag.
module bin32_to_bcd8
  import bin32_to_bcd8_pkg::*;
#(
  parameter int unsigned NUM_BITS   = NUM_BITS_DEF,
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    start,
  input  logic [NUM_BITS-1:0]     bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int unsigned SCR   = scratch_digits(NUM_BITS, NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  state_t                  state, state_nxt;
  logic [NUM_BITS-1:0]     shreg, shreg_nxt;
  logic [4*SCR-1:0]        scratch, scratch_nxt, adj;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    busy_nxt, done_nxt, ovf_nxt;
  logic [4*NUM_DIGITS-1:0] bcd_nxt;
  logic                    upper_nz;

  for (genvar i = 0; i < SCR; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  assign upper_nz = |scratch[4*SCR-1:4*NUM_DIGITS];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      scratch <= scratch_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      bcd     <= bcd_nxt;
      ovf     <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    scratch_nxt = scratch;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    bcd_nxt     = bcd;
    ovf_nxt     = ovf;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_nxt   = bin;
          scratch_nxt = '0;
          cnt_nxt     = '0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(NUM_BITS - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (upper_nz) begin
          bcd_nxt = {NUM_DIGITS{4'h9}};
          ovf_nxt = 1'b1;
        end else begin
          bcd_nxt = scratch[4*NUM_DIGITS-1:0];
          ovf_nxt = 1'b0;
        end
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin32_to_bcd8.sv
// Self-checking bench for bin32_to_bcd8 against an arithmetic decimal model.
module tb_bin32_to_bcd8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start;
  logic [31:0] bin;
  logic        busy, done, ovf;
  logic [31:0] bcd;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 CLK = ~CLK;

  bin32_to_bcd8 #(.NUM_BITS(32), .NUM_DIGITS(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    longint unsigned x;
    logic [31:0] r;
    x = v;
    if (x > 64'd99999999) return 32'h99999999;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
  task automatic convert(input logic [31:0] v, input bit chk_busy, input int glitch_k);
    logic [31:0] eb;
    logic        eo;
    eb = ref_bcd(v);
    eo = (v > 32'd99999999);
    start = 1'b1;
    bin   = v;
    @(posedge CLK); #1;
    start = 1'b0;
    bin   = $urandom;
    for (int k = 1; k <= 33; k++) begin
      if (k == glitch_k) begin
        start = 1'b1;
        bin   = 32'd5;
      end
      @(posedge CLK); #1;
      start = 1'b0;
      bin   = $urandom;
      if (k < 33) begin
        chk("done_low_during_conv", {31'b0, done}, 32'd0);
        if (chk_busy) chk("busy_high", {31'b0, busy}, 32'd1);
      end
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_low_at_done", {31'b0, busy}, 32'd0);
    chk("bcd", bcd, eb);
    chk("ovf", {31'b0, ovf}, {31'b0, eo});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] held;
    bit          saw_done;

    RST_N = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_bcd",  bcd, 32'd0);
    chk("rst_ovf",  {31'b0, ovf}, 32'd0);

    RST_N = 1'b1;
    convert(32'h0000_0000, 1'b1, 0);
    @(posedge CLK); #1;
    chk("done_clears", {31'b0, done}, 32'd0);

    convert(32'h00BC_614E, 1'b0, 0);
    @(posedge CLK); #1;
    convert(32'h05F5_E0FF, 1'b0, 0);
    @(posedge CLK); #1;
    convert(32'h05F5_E100, 1'b0, 0);
    @(posedge CLK); #1;
    convert(32'hFFFF_FFFF, 1'b0, 0);
    // back-to-back: start raised in the done cycle
    convert(32'h0000_0007, 1'b1, 0);
    repeat (5) begin
      @(posedge CLK); #1;
      chk("idle_no_done", {31'b0, done}, 32'd0);
      chk("bcd_holds", bcd, 32'h0000_0007);
    end

    convert(32'd42, 1'b1, 10);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) saw_done = 1'b1;
    end
    chk("single_done_pulse", {31'b0, saw_done}, 32'd0);
    chk("bcd_holds_42", bcd, 32'h0000_0042);

    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? $urandom_range(0, 99999999) : $urandom;
      convert(v, 1'b0, 0);
      @(posedge CLK); #1;
    end

    convert(32'd42, 1'b0, 0);
    @(posedge CLK); #1;
    held  = bcd;
    chk("pre_reset_bcd", held, 32'h0000_0042);
    start = 1'b1;
    bin   = 32'd98765;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (15) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_bcd",  bcd, 32'd0);
    chk("abort_ovf",  {31'b0, ovf}, 32'd0);
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge CLK); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, saw_done}, 32'd0);
    RST_N = 1'b1;
    convert(32'd98765, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
